fu_arbiter: RTL and testbench
=============================

Name: fu_arbiter

Overview:
- Shares the single external-ALU functional unit between NREQ decode-side requesters.
- Each requester presents a complete operation (ALUOP, OP1, OP2). The arbiter grants requesters round-robin and sequences the FU write/read protocol (wr_aluop, wr_op1, wr_op2, rd_op3) on the FU command port.
- It returns OP3 to the granted requester.
- Sits between the decode stage and FU_STAGE, driving the FU command fields and consuming the FU status/result.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DBITS, 32, operand/result width.
- AOPBITS, 4, ALUOP width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation request.
- req_aluop  in  NREQ*AOPBITS  requester i's ALUOP at [i*AOPBITS +: AOPBITS].
- req_op1  in  NREQ*DBITS  requester i's OP1 at [i*DBITS +: DBITS].
- req_op2  in  NREQ*DBITS  requester i's OP2, same packing as req_op1.
- req_ready  out  NREQ  one-hot, 1-cycle pulse: request i accepted this cycle.
- resp_valid  out  NREQ  one-hot, 1-cycle pulse: result for requester i on resp_data.
- resp_data  out  DBITS  result (OP3) of the completed operation.
- busy  out  1  high from acceptance until the resp_valid cycle inclusive.
- fu_wr_aluop  out  1  FU command: ALUOP write strobe.
- fu_wr_op1  out  1  FU command: OP1 write strobe.
- fu_wr_op2  out  1  FU command: OP2 write strobe.
- fu_wr_data  out  DBITS  FU write data; ALUOP zero-extended.
- fu_rd_op3  out  1  FU command: result read strobe.
- fu_csr  in  3  FU status (CSR_ALU_OUT); bit0 = OP2 acceptable, bit2 = compute done.
- fu_op3  in  DBITS  FU result.

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE.
  - All outputs 0.
  - Round-robin pointer = 0.
  - Latched operation registers = 0.
  - Reset mid-operation abandons the operation: no resp_valid. The FU is reset by the same reset.
- States: IDLE, S_AOP, S_OP1, S_OP2, S_WAIT, S_READ, S_RESP.
- IDLE:
  - If any req_valid, grant the first valid index at or after the pointer, wrapping modulo NREQ.
  - Pulse req_ready[g] in the same cycle.
  - Latch aluop/op1/op2 and the grant index.
  - Set pointer = (g+1) mod NREQ. Go to S_AOP.
  - No request: stay in IDLE, outputs 0.
- S_AOP: fu_wr_aluop=1, fu_wr_data={0,aluop} for exactly one cycle, then S_OP1.
- S_OP1: fu_wr_op1=1, fu_wr_data=op1 for exactly one cycle, then S_OP2.
- S_OP2:
  - Hold fu_wr_op2=1, fu_wr_data=op2 every cycle.
  - Leave for S_WAIT at the end of the first cycle in which fu_csr[0]=1. No bound on the wait.
- S_WAIT: all strobes 0. On fu_csr[2]=1, go to S_READ.
- S_READ:
  - fu_rd_op3=1 for one cycle.
  - Capture fu_op3 into the result register in that same cycle.
  - Then S_RESP.
- S_RESP:
  - resp_valid[g]=1, resp_data=captured result, for one cycle.
  - Then IDLE. A new grant is possible in the IDLE cycle that follows.
- At most one fu_* strobe is high in any cycle. fu_wr_data = 0 whenever no write strobe is high.
- Latency, acceptance to resp_valid with fu_csr[0] already high and fu_csr[2] arriving k cycles after S_WAIT entry: 5+k cycles.
- Request contract:
  - Requesters hold req_valid and operands stable until req_ready.
  - req_valid dropped before grant is legal and is not granted.
  - Operands are sampled only at grant; later changes are ignored.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester waits at most NREQ-1 grants (fairness).
- A requester may re-request in its own resp_valid cycle; it is considered at the next IDLE.
- resp_data holds the last result until the next S_READ.

Optional Feature:
- Macro FU_ARB_STATS_EN. When defined, adds outputs:
  - stat_ops (32): completed operations, incremented in S_RESP.
  - stat_stall (32): cycles spent in S_OP2 with fu_csr[0]=0 plus cycles in S_WAIT.
  - Both reset to 0 and saturate at all-ones.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single op: req_valid=0001, aluop=ADD, op1=5, op2=7, fu model with csr[0]=1 and done after 3 cycles → req_ready[0] in grant cycle; strobe order aluop, op1, op2, rd_op3 one cycle each; resp_valid[0] with resp_data=12 at 8 cycles after grant.
- Contention: req_valid=1111 held continuously → grants in order 0,1,2,3,0; no requester granted twice before the others.
- OP2 backpressure: csr[0] low for 4 cycles in S_OP2 → fu_wr_op2 held 5 cycles with data stable; single transition to S_WAIT.
- Reset during S_WAIT → next cycle all outputs 0 and state IDLE; no resp_valid; a following request on index 2 completes normally.
- Pointer wrap: pointer=3, req_valid=0101 → grant 0, then 2.
- With FU_ARB_STATS_EN: three ops with 2 stall cycles each → stat_ops=3, stat_stall=6.

Source files
------------

// File: rtl/fu_arbiter_if.sv
// Requester and FU command/status bundle for fu_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the FU.
interface fu_arbiter_if #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DBITS   = 32,
    parameter int unsigned AOPBITS = 4
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*AOPBITS-1:0] req_aluop;
    logic [NREQ*DBITS-1:0]   req_op1;
    logic [NREQ*DBITS-1:0]   req_op2;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0]         resp_valid;
    logic [DBITS-1:0]        resp_data;
    logic                    busy;
    logic                    fu_wr_aluop;
    logic                    fu_wr_op1;
    logic                    fu_wr_op2;
    logic [DBITS-1:0]        fu_wr_data;
    logic                    fu_rd_op3;
    logic [2:0]              fu_csr;
    logic [DBITS-1:0]        fu_op3;

    modport master (
        output req_valid, req_aluop, req_op1, req_op2, fu_csr, fu_op3,
        input  req_ready, resp_valid, resp_data, busy,
        input  fu_wr_aluop, fu_wr_op1, fu_wr_op2, fu_wr_data, fu_rd_op3
    );

    modport slave (
        input  req_valid, req_aluop, req_op1, req_op2, fu_csr, fu_op3,
        output req_ready, resp_valid, resp_data, busy,
        output fu_wr_aluop, fu_wr_op1, fu_wr_op2, fu_wr_data, fu_rd_op3
    );
endinterface

// File: rtl/fu_arbiter.sv
// Round-robin arbiter sharing one external ALU between NREQ requesters.
// Optional counters stat_ops/stat_stall are built when FU_ARB_STATS_EN is defined.
module fu_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DBITS   = 32,
    parameter int unsigned AOPBITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    fu_arbiter_if.slave bus
`ifdef FU_ARB_STATS_EN
    ,
    output logic [31:0] stat_ops,
    output logic [31:0] stat_stall
`endif
);
    localparam int unsigned IdxW = $clog2(NREQ);
    localparam logic [NREQ-1:0] Lsb = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle, StAop, StOp1, StOp2, StWait, StRead, StResp
    } state_e;

    state_e            r_state;
    logic [IdxW-1:0]   r_ptr;
    logic [IdxW-1:0]   r_gidx;
    logic [DBITS-1:0]  r_op1;
    logic [DBITS-1:0]  r_op2;
    logic [DBITS-1:0]  r_result;
    logic [DBITS-1:0]  r_wr_data;
    logic              r_wr_aluop;
    logic              r_wr_op1;
    logic              r_wr_op2;
    logic              r_rd_op3;
    logic              r_busy;
    logic [NREQ-1:0]   r_resp_valid;

    logic              w_found;
    logic              w_grant;
    logic [IdxW-1:0]   w_gidx;
    logic [IdxW-1:0]   w_ptr_nxt;
    logic [IdxW:0]     w_sum;
    logic [AOPBITS-1:0] w_aluop;
    logic [DBITS-1:0]  w_op1;
    logic [DBITS-1:0]  w_op2;
    logic              w_unused_csr1;

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_sum   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IdxW+1)'(k);
            if (w_sum >= (IdxW+1)'(NREQ)) begin
                w_sum = w_sum - (IdxW+1)'(NREQ);
            end
            if (!w_found && bus.req_valid[w_sum[IdxW-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_sum[IdxW-1:0];
            end
        end
    end

    always_comb begin
        w_aluop = '0;
        w_op1   = '0;
        w_op2   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_gidx == IdxW'(i)) begin
                w_aluop = bus.req_aluop[i*AOPBITS +: AOPBITS];
                w_op1   = bus.req_op1[i*DBITS +: DBITS];
                w_op2   = bus.req_op2[i*DBITS +: DBITS];
            end
        end
    end

    assign w_ptr_nxt     = (w_gidx == IdxW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
    assign w_grant       = (r_state == StIdle) && w_found && !reset;
    assign w_unused_csr1 = bus.fu_csr[1];

    assign bus.req_ready   = w_grant ? (Lsb << w_gidx) : '0;
    assign bus.busy        = r_busy | w_grant;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_data   = r_result;
    assign bus.fu_wr_aluop = r_wr_aluop;
    assign bus.fu_wr_op1   = r_wr_op1;
    assign bus.fu_wr_op2   = r_wr_op2;
    assign bus.fu_wr_data  = r_wr_data;
    assign bus.fu_rd_op3   = r_rd_op3;

    // Strobes are registered: each is set on entry to its state and cleared on exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_ptr        <= '0;
            r_gidx       <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_result     <= '0;
            r_wr_data    <= '0;
            r_wr_aluop   <= 1'b0;
            r_wr_op1     <= 1'b0;
            r_wr_op2     <= 1'b0;
            r_rd_op3     <= 1'b0;
            r_busy       <= 1'b0;
            r_resp_valid <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_state    <= StAop;
                        r_gidx     <= w_gidx;
                        r_ptr      <= w_ptr_nxt;
                        r_op1      <= w_op1;
                        r_op2      <= w_op2;
                        r_busy     <= 1'b1;
                        r_wr_aluop <= 1'b1;
                        r_wr_data  <= DBITS'(w_aluop);
                    end
                end
                StAop: begin
                    r_state    <= StOp1;
                    r_wr_aluop <= 1'b0;
                    r_wr_op1   <= 1'b1;
                    r_wr_data  <= r_op1;
                end
                StOp1: begin
                    r_state   <= StOp2;
                    r_wr_op1  <= 1'b0;
                    r_wr_op2  <= 1'b1;
                    r_wr_data <= r_op2;
                end
                StOp2: begin
                    if (bus.fu_csr[0]) begin
                        r_state   <= StWait;
                        r_wr_op2  <= 1'b0;
                        r_wr_data <= '0;
                    end
                end
                StWait: begin
                    if (bus.fu_csr[2]) begin
                        r_state  <= StRead;
                        r_rd_op3 <= 1'b1;
                    end
                end
                StRead: begin
                    r_state      <= StResp;
                    r_rd_op3     <= 1'b0;
                    r_result     <= bus.fu_op3;
                    r_resp_valid <= Lsb << r_gidx;
                end
                StResp: begin
                    r_state      <= StIdle;
                    r_resp_valid <= '0;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

`ifdef FU_ARB_STATS_EN
    logic [31:0] r_stat_ops;
    logic [31:0] r_stat_stall;
    logic        w_stall;

    assign w_stall = ((r_state == StOp2) && !bus.fu_csr[0]) || (r_state == StWait);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_ops   <= '0;
            r_stat_stall <= '0;
        end else begin
            if ((r_state == StResp) && (r_stat_ops != '1)) begin
                r_stat_ops <= r_stat_ops + 32'd1;
            end
            if (w_stall && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_ops   = r_stat_ops;
    assign stat_stall = r_stat_stall;
`endif
endmodule

// File: tb/tb_fu_arbiter.sv
// Directed bench for fu_arbiter with a small behavioural FU on the command port.
module tb_fu_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    fu_arbiter_if #(.NREQ(4), .DBITS(32), .AOPBITS(4)) bus ();

`ifdef FU_ARB_STATS_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_stall;
`endif

    fu_arbiter #(.NREQ(4), .DBITS(32), .AOPBITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus)
`ifdef FU_ARB_STATS_EN
        ,
        .stat_ops   (stat_ops),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // FU model: fu_acc drives csr[0]; done rises fu_delay cycles after OP2 is taken.
    logic        fu_acc;
    int unsigned fu_delay;
    logic [3:0]  m_aop;
    logic [31:0] m_a;
    logic [31:0] m_b;
    int unsigned m_cnt;
    logic        m_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_aop  <= '0;
            m_a    <= '0;
            m_b    <= '0;
            m_cnt  <= 0;
            m_pend <= 1'b0;
        end else begin
            if (bus.fu_wr_aluop) m_aop <= bus.fu_wr_data[3:0];
            if (bus.fu_wr_op1) m_a <= bus.fu_wr_data;
            if (bus.fu_wr_op2 && fu_acc) begin
                m_b    <= bus.fu_wr_data;
                m_cnt  <= fu_delay;
                m_pend <= 1'b1;
            end else if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end
            if (bus.fu_rd_op3) m_pend <= 1'b0;
        end
    end

    assign bus.fu_csr = {m_pend && (m_cnt == 1), 1'b0, fu_acc};

    always_comb begin
        bus.fu_op3 = '0;
        case (m_aop)
            4'd1: bus.fu_op3 = m_a + m_b;
            4'd2: bus.fu_op3 = m_a - m_b;
            4'd3: bus.fu_op3 = m_a ^ m_b;
            default: bus.fu_op3 = '0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] strb();
        return {bus.fu_wr_aluop, bus.fu_wr_op1, bus.fu_wr_op2, bus.fu_rd_op3};
    endfunction

    task automatic nc();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [31:0] x,
                           input logic [31:0] y);
        bus.req_aluop[i*4 +: 4]  = a;
        bus.req_op1[i*32 +: 32]  = x;
        bus.req_op2[i*32 +: 32]  = y;
    endtask

    // Wait (bounded) for the grant of requester idx, then for its response.
    task automatic serve(input int idx, input bit hold, input logic [31:0] exp_data);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (|bus.req_ready) break;
        end
        check("grant", bus.req_ready, oh);
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid[idx] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (|bus.resp_valid) break;
        end
        check("resp_valid", bus.resp_valid, oh);
        check("resp_data", bus.resp_data, exp_data);
    endtask

    initial begin
        logic [3:0] acc;
        reset         = 1'b1;
        fu_acc        = 1'b1;
        fu_delay      = 3;
        bus.req_valid = 4'b1111;
        bus.req_aluop = '0;
        bus.req_op1   = '0;
        bus.req_op2   = '0;

        // Reset state, with requests present while reset is held.
        @(posedge clk);
        @(posedge clk);
        nc();
        check("rst_ready", bus.req_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_resp", bus.resp_valid, 0);
        check("rst_strb", strb(), 0);
        check("rst_wdata", bus.fu_wr_data, 0);
        check("rst_rdata", bus.resp_data, 0);
`ifdef FU_ARB_STATS_EN
        check("rst_stat_ops", stat_ops, 0);
        check("rst_stat_stall", stat_stall, 0);
`endif
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.req_valid = '0;
        nc();
        check("idle_busy", bus.busy, 0);
        check("idle_ready", bus.req_ready, 0);

        // Single ADD 5+7 with done three cycles into the wait.
        set_req(0, 4'd1, 32'd5, 32'd7);
        bus.req_valid = 4'b0001;
        #1;
        check("sg_ready", bus.req_ready, 4'b0001);
        check("sg_busy", bus.busy, 1);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        nc();
        check("c1_strb", strb(), 4'b1000);
        check("c1_data", bus.fu_wr_data, 1);
        nc();
        check("c2_strb", strb(), 4'b0100);
        check("c2_data", bus.fu_wr_data, 5);
        nc();
        check("c3_strb", strb(), 4'b0010);
        check("c3_data", bus.fu_wr_data, 7);
        nc();
        check("c4_strb", strb(), 0);
        check("c4_data", bus.fu_wr_data, 0);
        nc();
        nc();
        check("c6_strb", strb(), 0);
        nc();
        check("c7_strb", strb(), 4'b0001);
        check("c7_resp", bus.resp_valid, 0);
        nc();
        check("c8_resp", bus.resp_valid, 4'b0001);
        check("c8_rdata", bus.resp_data, 12);
        check("c8_busy", bus.busy, 1);
        nc();
        check("c9_resp", bus.resp_valid, 0);
        check("c9_busy", bus.busy, 0);
        check("c9_hold", bus.resp_data, 12);

        // Contention: all four held continuously.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        fu_delay = 1;
        for (int i = 0; i < 4; i++) set_req(i, 4'd1, 32'(100 + 10 * i), 32'(i));
        bus.req_valid = 4'b1111;
        serve(0, 1'b1, 32'd100);
        serve(1, 1'b1, 32'd111);
        serve(2, 1'b1, 32'd122);
        serve(3, 1'b1, 32'd133);
        serve(0, 1'b0, 32'd100);
        bus.req_valid = '0;

        // Walk the pointer to 3, then 0101 must grant 0 before 2.
        bus.req_valid = 4'b0010;
        serve(1, 1'b0, 32'd111);
        bus.req_valid = 4'b0100;
        serve(2, 1'b0, 32'd122);
        bus.req_valid = 4'b0101;
        serve(0, 1'b0, 32'd100);
        serve(2, 1'b0, 32'd122);

        // OP2 backpressure: csr[0] low for four S_OP2 cycles; operand changed after grant.
        set_req(3, 4'd2, 32'd100, 32'd30);
        fu_acc        = 1'b0;
        bus.req_valid = 4'b1000;
        nc();
        check("bp_ready", bus.req_ready, 4'b1000);
        @(posedge clk);
        #1;
        bus.req_valid            = '0;
        bus.req_op2[3*32 +: 32]  = 32'hdead_beef;
        nc();
        check("bp_c1_strb", strb(), 4'b1000);
        check("bp_c1_data", bus.fu_wr_data, 2);
        nc();
        check("bp_c2_data", bus.fu_wr_data, 100);
        for (int j = 0; j < 4; j++) begin
            nc();
            check("bp_hold_strb", strb(), 4'b0010);
            check("bp_hold_data", bus.fu_wr_data, 30);
        end
        @(posedge clk);
        #1;
        fu_acc = 1'b1;
        nc();
        check("bp_c7_strb", strb(), 4'b0010);
        check("bp_c7_data", bus.fu_wr_data, 30);
        nc();
        check("bp_wait_strb", strb(), 0);
        check("bp_wait_data", bus.fu_wr_data, 0);
        nc();
        check("bp_read", strb(), 4'b0001);
        nc();
        check("bp_resp", bus.resp_valid, 4'b1000);
        check("bp_rdata", bus.resp_data, 70);

        // Reset while waiting for done abandons the operation.
        set_req(1, 4'd3, 32'd8, 32'd9);
        fu_delay      = 10;
        bus.req_valid = 4'b0010;
        nc();
        check("rw_ready", bus.req_ready, 4'b0010);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        nc();
        nc();
        nc();
        nc();
        check("rw_wait_strb", strb(), 0);
        check("rw_wait_busy", bus.busy, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        nc();
        check("rw_busy", bus.busy, 0);
        check("rw_strb", strb(), 0);
        check("rw_wdata", bus.fu_wr_data, 0);
        check("rw_resp", bus.resp_valid, 0);
        check("rw_rdata", bus.resp_data, 0);
        acc = '0;
        for (int j = 0; j < 15; j++) begin
            nc();
            acc = acc | bus.resp_valid | {3'b000, bus.busy};
        end
        check("rw_quiet", acc, 0);
        fu_delay = 3;
        set_req(2, 4'd1, 32'd40, 32'd2);
        bus.req_valid = 4'b0100;
        serve(2, 1'b0, 32'd42);

`ifdef FU_ARB_STATS_EN
        // Three ops, each spending two cycles in S_WAIT.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        fu_delay = 2;
        nc();
        check("st_clr_ops", stat_ops, 0);
        check("st_clr_stall", stat_stall, 0);
        for (int j = 0; j < 3; j++) begin
            set_req(0, 4'd1, 32'd1, 32'd1);
            bus.req_valid = 4'b0001;
            serve(0, 1'b0, 32'd2);
        end
        nc();
        check("st_ops", stat_ops, 3);
        check("st_stall", stat_stall, 6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
